branch_target_predictor: RTL and testbench

- Next-PC generation stage that sits directly upstream of the PC register and drives its pc_i input.
- Each cycle it looks up the current fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It produces the next fetch address: the predicted target, PC+4, or an EX-stage redirect.
- Resolved branches from EX train the table.
- Holds hit/mispredict statistics counters for performance evaluation.

---
 rtl/branch_target_predictor.sv | 144 ++++++++++++++
 tb/tb_branch_target_predictor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Next-PC generation stage with a direct-mapped branch target buffer.
// Each BTB entry holds a valid bit, tag, target and 2-bit saturating counter.
// Lookup and next-PC selection are purely combinational on the fetch PC.
// EX-stage resolved branches train the table on the clock edge.
// Hit and mispredict statistics counters saturate at all-ones.
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        memStall_i,
    input  logic [31:0] pc_i,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        mispredict_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] next_pc_o,
    output logic        pred_taken_o,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    localparam int TAG_W = 32 - IDX_W - 2;

    // Table storage, current and next state
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    // Statistics counters
    logic [31:0] hitCnt_q, hitCnt_d;
    logic [31:0] mispredCnt_q, mispredCnt_d;

    // Lookup side
    logic [IDX_W-1:0] lookupIdx;
    logic [TAG_W-1:0] lookupTag;
    logic             lookupHit;

    // Update side
    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] updTag;
    logic             updHit;
    logic             pipeActive;
    logic             updEnable;

    assign lookupIdx  = pc_i[IDX_W+1:2];
    assign lookupTag  = pc_i[31:IDX_W+2];
    assign updIdx     = upd_pc_i[IDX_W+1:2];
    assign updTag     = upd_pc_i[31:IDX_W+2];
    assign pipeActive = start_i && !memStall_i;
    assign updEnable  = upd_valid_i && pipeActive;

    // Combinational BTB lookup and next fetch address selection
    always_comb begin
        lookupHit    = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
        pred_taken_o = lookupHit && ctr_q[lookupIdx][1];
        if (mispredict_i) begin
            next_pc_o = redirect_pc_i;
        end else if (pred_taken_o) begin
            next_pc_o = target_q[lookupIdx];
        end else begin
            next_pc_o = pc_i + 32'd4;
        end
    end

    assign updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);

    // Training: counter/target update on a hit, allocation on a taken miss
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (updEnable) begin
            if (updHit) begin
                if (upd_taken_i) begin
                    if (ctr_q[updIdx] != 2'b11) begin
                        ctr_d[updIdx] = ctr_q[updIdx] + 2'd1;
                    end
                    target_d[updIdx] = upd_target_i;
                end else begin
                    if (ctr_q[updIdx] != 2'b00) begin
                        ctr_d[updIdx] = ctr_q[updIdx] - 2'd1;
                    end
                end
            end else if (upd_taken_i) begin
                valid_d[updIdx]  = 1'b1;
                tag_d[updIdx]    = updTag;
                target_d[updIdx] = upd_target_i;
                ctr_d[updIdx]    = 2'b10;
            end
        end
    end

    // Saturating statistics, frozen while the CPU is idle or memory-stalled
    always_comb begin
        hitCnt_d     = hitCnt_q;
        mispredCnt_d = mispredCnt_q;
        if (pipeActive) begin
            if (lookupHit && !stall_i && (hitCnt_q != 32'hFFFF_FFFF)) begin
                hitCnt_d = hitCnt_q + 32'd1;
            end
            if (mispredict_i && (mispredCnt_q != 32'hFFFF_FFFF)) begin
                mispredCnt_d = mispredCnt_q + 32'd1;
            end
        end
    end

    // State registers; reset leaves every entry invalid and weakly not-taken
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= '0;
            hitCnt_q     <= '0;
            mispredCnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q      <= valid_d;
            hitCnt_q     <= hitCnt_d;
            mispredCnt_q <= mispredCnt_d;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

    assign hit_cnt_o     = hitCnt_q;
    assign mispred_cnt_o = mispredCnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed scenarios followed
// by randomized traffic, compared against a behavioural model of the BTB.
module tb_branch_target_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        stall_i;
    logic        memStall_i;
    logic [31:0] pc_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        mispredict_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] next_pc_o;
    logic        pred_taken_o;
    logic [31:0] hit_cnt_o;
    logic [31:0] mispred_cnt_o;

    int checks = 0;
    int failures = 0;

    // Behavioural model of the table: index = (pc/4) mod 16, tag = pc/64
    bit          mValid  [16];
    int unsigned mTag    [16];
    int unsigned mTarget [16];
    int          mCtr    [16];
    int unsigned mHits;
    int unsigned mMispreds;

    always #5 clk_i = ~clk_i;

    branch_target_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .start_i(start_i),
        .stall_i(stall_i),
        .memStall_i(memStall_i),
        .pc_i(pc_i),
        .upd_valid_i(upd_valid_i),
        .upd_pc_i(upd_pc_i),
        .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i),
        .mispredict_i(mispredict_i),
        .redirect_pc_i(redirect_pc_i),
        .next_pc_o(next_pc_o),
        .pred_taken_o(pred_taken_o),
        .hit_cnt_o(hit_cnt_o),
        .mispred_cnt_o(mispred_cnt_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mValid[i]  = 1'b0;
            mTag[i]    = 0;
            mTarget[i] = 0;
            mCtr[i]    = 1;
        end
        mHits     = 0;
        mMispreds = 0;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic start, input logic stall,
                                 input logic memStall, input logic updValid, input logic [31:0] updPc,
                                 input logic updTaken, input logic [31:0] updTarget,
                                 input logic mis, input logic [31:0] redirect);
        pc_i          = pc;
        start_i       = start;
        stall_i       = stall;
        memStall_i    = memStall;
        upd_valid_i   = updValid;
        upd_pc_i      = updPc;
        upd_taken_i   = updTaken;
        upd_target_i  = updTarget;
        mispredict_i  = mis;
        redirect_pc_i = redirect;
    endtask

    // Called shortly after a negedge: checks the combinational outputs against
    // the model, then lets one clock edge pass and trains the model identically.
    task automatic stepCycle();
        int          li;
        int          ui;
        bit          lHit;
        bit          uHit;
        bit          expPred;
        logic [31:0] expNext;
        li      = int'((pc_i >> 2) & 32'hF);
        lHit    = mValid[li] && (mTag[li] == (pc_i >> 6));
        expPred = lHit && (mCtr[li] >= 2);
        if (mispredict_i)  expNext = redirect_pc_i;
        else if (expPred)  expNext = mTarget[li];
        else               expNext = pc_i + 32'd4;
        #1;
        checkOutput("pred_taken", {31'd0, pred_taken_o}, {31'd0, expPred});
        checkOutput("next_pc", next_pc_o, expNext);
        checkOutput("hit_cnt", hit_cnt_o, mHits);
        checkOutput("mispred_cnt", mispred_cnt_o, mMispreds);
        @(posedge clk_i);
        if (start_i && !memStall_i) begin
            if (lHit && !stall_i && mHits != 32'hFFFF_FFFF) mHits++;
            if (mispredict_i && mMispreds != 32'hFFFF_FFFF) mMispreds++;
            if (upd_valid_i) begin
                ui   = int'((upd_pc_i >> 2) & 32'hF);
                uHit = mValid[ui] && (mTag[ui] == (upd_pc_i >> 6));
                if (uHit) begin
                    if (upd_taken_i) begin
                        mCtr[ui]    = (mCtr[ui] < 3) ? mCtr[ui] + 1 : 3;
                        mTarget[ui] = upd_target_i;
                    end else begin
                        mCtr[ui] = (mCtr[ui] > 0) ? mCtr[ui] - 1 : 0;
                    end
                end else if (upd_taken_i) begin
                    mValid[ui]  = 1'b1;
                    mTag[ui]    = upd_pc_i >> 6;
                    mTarget[ui] = upd_target_i;
                    mCtr[ui]    = 2;
                end
            end
        end
        @(negedge clk_i);
    endtask

    task automatic lookupOnly(input logic [31:0] pc);
        applyStimulus(pc, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic trainOnly(input logic [31:0] pc, input logic [31:0] updPc, input logic taken,
                             input logic [31:0] target);
        applyStimulus(pc, 1'b1, 1'b0, 1'b0, 1'b1, updPc, taken, target, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] randomPc();
        logic [31:0] pool [7];
        pool[0] = 32'h40;  pool[1] = 32'h440; pool[2] = 32'h80; pool[3] = 32'h840;
        pool[4] = 32'h3C;  pool[5] = 32'hFFFF_FFFC; pool[6] = $urandom() & 32'hFFFF_FFFC;
        return pool[$urandom_range(6, 0)];
    endfunction

    task automatic randomCycle();
        applyStimulus(randomPc(), ($urandom_range(9, 0) != 0), ($urandom_range(4, 0) == 0),
                      ($urandom_range(9, 0) == 0), $urandom_range(1, 0) == 1, randomPc(),
                      $urandom_range(1, 0) == 1, $urandom() & 32'hFFFF_FFFC,
                      ($urandom_range(6, 0) == 0), $urandom() & 32'hFFFF_FFFC);
        stepCycle();
    endtask

    initial begin
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst_i = 1'b1;
        modelReset();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        // Reset state
        lookupOnly(32'h40);
        #1;
        checkOutput("rst_next_pc", next_pc_o, 32'h44);
        checkOutput("rst_hit_cnt", hit_cnt_o, 32'h0);
        checkOutput("rst_mispred_cnt", mispred_cnt_o, 32'h0);
        stepCycle();

        // Allocate 0x40 -> 0x100, then hit
        trainOnly(32'h80, 32'h40, 1'b1, 32'h100);
        stepCycle();
        lookupOnly(32'h40);
        #1;
        checkOutput("alloc_pred", {31'd0, pred_taken_o}, 32'd1);
        checkOutput("alloc_next_pc", next_pc_o, 32'h100);
        stepCycle();
        lookupOnly(32'h80);
        #1;
        checkOutput("alloc_hit_cnt", hit_cnt_o, 32'd1);
        stepCycle();

        // Two not-taken trainings drop the counter to strongly not-taken
        repeat (2) begin
            trainOnly(32'h80, 32'h40, 1'b0, 32'h0);
            stepCycle();
        end
        lookupOnly(32'h40);
        #1;
        checkOutput("nt_next_pc", next_pc_o, 32'h44);
        stepCycle();
        repeat (3) begin
            trainOnly(32'h40, 32'h40, 1'b1, 32'h100);
            stepCycle();
        end
        lookupOnly(32'h40);
        stepCycle();
        // Saturated counter survives one not-taken and still predicts taken
        trainOnly(32'h80, 32'h40, 1'b0, 32'h0);
        stepCycle();
        lookupOnly(32'h40);
        #1;
        checkOutput("sat_pred", {31'd0, pred_taken_o}, 32'd1);
        stepCycle();

        // Aliasing at the same index
        trainOnly(32'h80, 32'h440, 1'b1, 32'h300);
        stepCycle();
        lookupOnly(32'h40);
        #1;
        checkOutput("alias_old_next_pc", next_pc_o, 32'h44);
        stepCycle();
        lookupOnly(32'h440);
        #1;
        checkOutput("alias_new_next_pc", next_pc_o, 32'h300);
        stepCycle();

        // Redirect beats a taken prediction
        applyStimulus(32'h440, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h200);
        #1;
        checkOutput("redirect_next_pc", next_pc_o, 32'h200);
        stepCycle();
        lookupOnly(32'h80);
        #1;
        checkOutput("redirect_mispred_cnt", mispred_cnt_o, 32'd1);
        stepCycle();

        // Gating: memStall and start low block training and statistics
        applyStimulus(32'h440, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h500, 1'b1, 32'h600);
        stepCycle();
        applyStimulus(32'h440, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h500, 1'b1, 32'h600);
        stepCycle();
        lookupOnly(32'h80);
        #1;
        checkOutput("gate_next_pc", next_pc_o, 32'h84);
        checkOutput("gate_mispred_cnt", mispred_cnt_o, 32'd1);
        stepCycle();

        // PC wrap
        lookupOnly(32'hFFFF_FFFC);
        #1;
        checkOutput("wrap_next_pc", next_pc_o, 32'h0);
        stepCycle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) randomCycle();

        // Asynchronous reset mid-run
        trainOnly(32'h80, 32'h40, 1'b1, 32'h100);
        stepCycle();
        lookupOnly(32'h40);
        #2;
        rst_i = 1'b1;
        #1;
        modelReset();
        checkOutput("midrst_pred", {31'd0, pred_taken_o}, 32'd0);
        checkOutput("midrst_next_pc", next_pc_o, 32'h44);
        checkOutput("midrst_hit_cnt", hit_cnt_o, 32'h0);
        checkOutput("midrst_mispred_cnt", mispred_cnt_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int n = 0; n < 100; n++) randomCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
